alu_exec_stage: RTL and testbench



---
 rtl/alu_exec_stage.sv | 146 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, 1-bit-per-cycle shifts, valid/ready on both sides.
// Optional overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [SW-1:0]    count;
    logic [1:0]       shift_kind;

    logic [WIDTH-1:0] sum, diff, alu_result, shift_next;
    logic             alu_illegal, slt, is_shift, accept;
    logic [SW-1:0]    shamt;
`ifdef ALU_OVERFLOW_EN
    logic             alu_ovf;
`endif

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SW-1:0];
    assign sum      = a + b;
    assign diff     = a - b;
    assign slt      = $signed(a) < $signed(b);
    assign is_shift = (operation == OP_SLL) || (operation == OP_SRL) || (operation == OP_SRA);

    // A shift only reaches this path with shamt==0, where the result is just a.
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (operation)
            OP_AND:                 alu_result = a & b;
            OP_OR:                  alu_result = a | b;
            OP_ADD:                 alu_result = sum;
            OP_SUB:                 alu_result = diff;
            OP_SLT:                 alu_result = {{(WIDTH-1){1'b0}}, slt};
            OP_XOR:                 alu_result = a ^ b;
            OP_SLL, OP_SRL, OP_SRA: alu_result = a;
            default:                alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    always_comb begin
        alu_ovf = 1'b0;
        if (operation == OP_ADD)
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        else if (operation == OP_SUB)
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    always_comb begin
        case (shift_kind)
            2'b00:   shift_next = {shreg[WIDTH-2:0], 1'b0};
            2'b01:   shift_next = {1'b0, shreg[WIDTH-1:1]};
            default: shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            count      <= '0;
            shift_kind <= 2'b00;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            illegal    <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_shift && (shamt != '0)) begin
                        // Output register is empty or draining this edge, so it can go invalid.
                        shreg      <= a;
                        count      <= shamt;
                        shift_kind <= operation[1:0];
                        out_valid  <= 1'b0;
                        state      <= SHIFT;
                    end else if (accept) begin
                        result    <= alu_result;
                        zero      <= (alu_result == '0);
                        illegal   <= alu_illegal;
                        out_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
                        overflow  <= alu_ovf;
`endif
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg <= shift_next;
                    count <= count - 1'b1;
                    if (count == SW'(1)) begin
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
`ifdef ALU_OVERFLOW_EN
                        overflow  <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (WIDTH=32); checks overflow too when ALU_OVERFLOW_EN is defined.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
`ifdef ALU_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkOverflow(input string tag, input logic expected);
`ifdef ALU_OVERFLOW_EN
        checkOutput(tag, {31'b0, overflow}, {31'b0, expected});
`endif
    endtask

    task automatic checkResult(input string tag, input logic [31:0] exp_res,
                               input logic exp_zero, input logic exp_ill, input logic exp_ovf);
        checkOutput({tag, ".out_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, ".result"},    result,             exp_res);
        checkOutput({tag, ".zero"},      {31'b0, zero},      {31'b0, exp_zero});
        checkOutput({tag, ".illegal"},   {31'b0, illegal},   {31'b0, exp_ill});
        checkOverflow({tag, ".overflow"}, exp_ovf);
    endtask

    // Called #1 after an edge; presents one op for exactly one edge.
    task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
        operation = op;
        a         = aa;
        b         = bb;
        in_valid  = 1'b1;
        #1;
        checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        operation = 4'b0000;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst.result",    result,             32'd0);
        checkOutput("rst.zero",      {31'b0, zero},      32'd0);
        checkOutput("rst.illegal",   {31'b0, illegal},   32'd0);
        checkOverflow("rst.overflow", 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        checkResult("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus("sub_zero", 4'b0110, 32'd5, 32'd5);
        checkResult("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1);
        checkResult("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF);
        checkResult("slt_pos", 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("xor", 4'b1100, 32'h0000_F0F0, 32'h0000_0FF0);
        checkResult("xor", 32'h0000_FF00, 1'b0, 1'b0, 1'b0);
        applyStimulus("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        checkResult("and", 32'h00F0_1200, 1'b0, 1'b0, 1'b0);
        applyStimulus("or", 4'b0001, 32'hF000_0001, 32'h0000_0F00);
        checkResult("or", 32'hF000_0F01, 1'b0, 1'b0, 1'b0);
        applyStimulus("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
        checkResult("add_wrap", 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1);
        checkResult("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus("illegal", 4'b0101, 32'd7, 32'd3);
        checkResult("illegal", 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus("sll0", 4'b1000, 32'h0000_1234, 32'd0);
        checkResult("sll0", 32'h0000_1234, 1'b0, 1'b0, 1'b0);

        // Idle with out_ready high: the held result drains.
        @(posedge clk);
        #1;
        checkOutput("drain.out_valid", {31'b0, out_valid}, 32'd0);

        applyStimulus("sra4", 4'b1010, 32'h8000_0000, 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("sra4.busy%0d.in_ready", i), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("sra4.busy%0d.out_valid", i), {31'b0, out_valid}, 32'd0);
            if (i < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        checkResult("sra4", 32'hF800_0000, 1'b0, 1'b0, 1'b0);

        applyStimulus("srl_hib", 4'b1001, 32'hF000_0000, 32'h0000_0024);
        repeat (4) @(posedge clk);
        #1;
        checkResult("srl_hib", 32'h0F00_0000, 1'b0, 1'b0, 1'b0);

        applyStimulus("sll31", 4'b1000, 32'd1, 32'd31);
        repeat (31) @(posedge clk);
        #1;
        checkResult("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

        // Back-pressure: a held result blocks a new op until out_ready rises.
        applyStimulus("bp_first", 4'b0010, 32'd1, 32'd2);
        checkResult("bp_first", 32'd3, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        operation = 4'b1100;
        a         = 32'h0000_00FF;
        b         = 32'h0000_000F;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp%0d.in_ready", i), {31'b0, in_ready}, 32'd0);
            checkOutput($sformatf("bp%0d.out_valid", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("bp%0d.result", i), result, 32'd3);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release.in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkResult("bp_second", 32'h0000_00F0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a 10-step shift.
        applyStimulus("srl10", 4'b1001, 32'hFFFF_FFFF, 32'd10);
        checkOutput("srl10.busy.in_ready", {31'b0, in_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_rst.in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("async_rst.out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("post_rst.in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post_rst%0d.out_valid", i), {31'b0, out_valid}, 32'd0);
        end
        checkOutput("post_rst.result", result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
